// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm slice: state codes, field limits and field select.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_t;

    localparam int DEF_HOUR_MAX = 23;
    localparam int DEF_MIN_MAX  = 59;

    localparam logic SEL_MIN  = 1'b0;
    localparam logic SEL_HOUR = 1'b1;

    // Counter width for a count of n seconds, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrap_updown_cnt.sv
// Settable field counter that wraps at MAX going up and at 0 going down.
module wrap_updown_cnt #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TOP = W'(MAX);

    // inc and dec together cancel out, leaving the field unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (en && inc && !dec) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (en && dec && !inc) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm time store plus ring/snooze/timeout state machine driven by the 1 Hz tick.
module alarm_unit
    import clock_pkg::*;
#(
    parameter int W           = 6,
    parameter int HOUR_MAX    = DEF_HOUR_MAX,
    parameter int MIN_MAX     = DEF_MIN_MAX,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick_sec,
    input  logic         setting,
    input  logic         sel_field,
    input  logic         step_up,
    input  logic         step_down,
    input  logic         alarm_on,
    input  logic [W-1:0] cur_hour,
    input  logic [W-1:0] cur_min,
    input  logic [W-1:0] cur_sec,
    input  logic         snooze,
    input  logic         stop,
    output logic [W-1:0] alarm_hour,
    output logic [W-1:0] alarm_min,
    output logic         ringing,
    output logic [1:0]   state
);

    localparam int RW = cnt_width(RING_SECS);
    localparam int SW = cnt_width(SNOOZE_SECS);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);

    alarm_state_t  state_q;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic          hour_en;
    logic          min_en;
    logic          time_match;
    logic          force_idle;

    assign hour_en = setting && (sel_field == SEL_HOUR);
    assign min_en  = setting && (sel_field == SEL_MIN);

    wrap_updown_cnt #(.W(W), .MAX(HOUR_MAX)) u_hour (
        .clock (clock),
        .reset (reset),
        .en    (hour_en),
        .inc   (step_up),
        .dec   (step_down),
        .value (alarm_hour)
    );

    wrap_updown_cnt #(.W(W), .MAX(MIN_MAX)) u_min (
        .clock (clock),
        .reset (reset),
        .en    (min_en),
        .inc   (step_up),
        .dec   (step_down),
        .value (alarm_min)
    );

    // Second zero pins the trigger to a single tick per matching minute.
    assign time_match = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == '0);
    assign force_idle = setting || !alarm_on;

    // tick_sec, step_up, step_down, snooze and stop are single-cycle pulses sampled on
    // the rising edge; there is no back-pressure, every pulse is acted on in its own cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else if (force_idle) begin
            state_q  <= ST_IDLE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_sec && time_match) begin
                        state_q  <= ST_RING;
                        ringing  <= 1'b1;
                        ring_cnt <= '0;
                    end
                end
                ST_RING: begin
                    if (stop) begin
                        state_q  <= ST_IDLE;
                        ringing  <= 1'b0;
                        ring_cnt <= '0;
                    end else if (snooze) begin
                        state_q  <= ST_SNOOZE;
                        ringing  <= 1'b0;
                        ring_cnt <= '0;
                        snz_cnt  <= '0;
                    end else if (tick_sec) begin
                        if (ring_cnt == RING_LAST) begin
                            state_q  <= ST_IDLE;
                            ringing  <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        ringing <= 1'b0;
                        snz_cnt <= '0;
                    end else if (tick_sec) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state_q  <= ST_RING;
                            ringing  <= 1'b1;
                            ring_cnt <= '0;
                            snz_cnt  <= '0;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ringing  <= 1'b0;
                    ring_cnt <= '0;
                    snz_cnt  <= '0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit with a seconds-remaining reference model checked every cycle.
module tb_alarm_unit;

    localparam int W           = 6;
    localparam int RING_SECS   = 4;
    localparam int SNOOZE_SECS = 3;
    localparam int HOURS       = 24;
    localparam int MINS        = 60;

    logic         clock;
    logic         reset;
    logic         tick_sec;
    logic         setting;
    logic         sel_field;
    logic         step_up;
    logic         step_down;
    logic         alarm_on;
    logic [W-1:0] cur_hour;
    logic [W-1:0] cur_min;
    logic [W-1:0] cur_sec;
    logic         snooze;
    logic         stop;
    logic [W-1:0] alarm_hour;
    logic [W-1:0] alarm_min;
    logic         ringing;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    alarm_unit #(
        .W(W), .HOUR_MAX(23), .MIN_MAX(59),
        .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_sec   (tick_sec),
        .setting    (setting),
        .sel_field  (sel_field),
        .step_up    (step_up),
        .step_down  (step_down),
        .alarm_on   (alarm_on),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .snooze     (snooze),
        .stop       (stop),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .ringing    (ringing),
        .state      (state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end in time, got timeout, required finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0 quiet, 1 ringing, 2 snoozing; seconds left counted down.
    int m_hour, m_min, m_mode, ring_left, snz_left, m_delta;
    bit m_trig;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_hour = 0; m_min = 0; m_mode = 0; ring_left = 0; snz_left = 0;
        end else begin
            m_trig = tick_sec && (int'(cur_hour) == m_hour) && (int'(cur_min) == m_min)
                     && (cur_sec == 0);
            if (setting && (step_up != step_down)) begin
                m_delta = step_up ? 1 : -1;
                if (sel_field) m_hour = (m_hour + m_delta + HOURS) % HOURS;
                else           m_min  = (m_min + m_delta + MINS) % MINS;
            end
            if (setting || !alarm_on) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_trig) begin
                    m_mode = 1; ring_left = RING_SECS;
                end
            end else if (m_mode == 1) begin
                if (stop) m_mode = 0;
                else if (snooze) begin
                    m_mode = 2; snz_left = SNOOZE_SECS;
                end else if (tick_sec) begin
                    ring_left--;
                    if (ring_left == 0) m_mode = 0;
                end
            end else begin
                if (stop) m_mode = 0;
                else if (tick_sec) begin
                    snz_left--;
                    if (snz_left == 0) begin
                        m_mode = 1; ring_left = RING_SECS;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: DUT against model on every falling edge outside reset
    always @(negedge clock) begin
        if (!reset) begin
            check("cmp_hour",    32'(alarm_hour), 32'(m_hour));
            check("cmp_min",     32'(alarm_min),  32'(m_min));
            check("cmp_ringing", 32'(ringing),    32'(m_mode == 1));
            check("cmp_state",   32'(state),      32'(m_mode));
        end
    end

    // driver tasks: entered and left on a falling edge
    task automatic pulse_step(input logic up, input logic dn);
        step_up = up; step_down = dn;
        @(negedge clock);
        step_up = 1'b0; step_down = 1'b0;
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        cur_hour = W'(h); cur_min = W'(m); cur_sec = W'(s);
        tick_sec = 1'b1;
        @(negedge clock);
        tick_sec = 1'b0;
    endtask

    task automatic pulse_user(input logic snz, input logic stp);
        snooze = snz; stop = stp;
        @(negedge clock);
        snooze = 1'b0; stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_sec = 0; setting = 0; sel_field = 0; step_up = 0; step_down = 0;
        alarm_on = 0; cur_hour = '0; cur_min = '0; cur_sec = '0; snooze = 0; stop = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_hour", 32'(alarm_hour), 0);
        check("reset_min",  32'(alarm_min),  0);
        check("reset_ring", 32'(ringing),    0);
        check("reset_state", 32'(state),     0);

        // hour wraps 23 -> 0 going up, 0 -> 23 going down
        setting = 1; sel_field = 1;
        for (int i = 0; i < 24; i++) begin
            pulse_step(1, 0);
            check("hour_up", 32'(alarm_hour), (i < 23) ? i + 1 : 0);
        end
        pulse_step(0, 1);
        check("hour_down_wrap", 32'(alarm_hour), 23);

        sel_field = 0;
        pulse_step(1, 1);
        check("min_both", 32'(alarm_min), 0);
        pulse_step(0, 1);
        check("min_down_wrap", 32'(alarm_min), 59);

        // set 07:30: hour 23 +8, minute 59 -29
        sel_field = 1;
        repeat (8) pulse_step(1, 0);
        sel_field = 0;
        repeat (29) pulse_step(0, 1);
        check("set_hour", 32'(alarm_hour), 7);
        check("set_min",  32'(alarm_min),  30);

        setting = 0; sel_field = 1;
        pulse_step(1, 0);
        check("step_ignored", 32'(alarm_hour), 7);

        // trigger, stop, no retrigger at second 1
        alarm_on = 1;
        tick_at(7, 29, 0);
        check("no_match", 32'(ringing), 0);
        tick_at(7, 30, 0);
        check("trig_ring",  32'(ringing), 1);
        check("trig_state", 32'(state),   1);
        pulse_user(0, 1);
        check("stop_ring", 32'(ringing), 0);
        tick_at(7, 30, 1);
        check("no_retrig", 32'(ringing), 0);

        // timeout after RING_SECS ticks
        tick_at(7, 30, 0);
        for (int i = 1; i <= RING_SECS; i++) begin
            tick_at(7, 30, i);
            check("timeout_ring", 32'(ringing), (i < RING_SECS) ? 1 : 0);
        end
        check("timeout_state", 32'(state), 0);

        // snooze, ignored repeat snooze, re-ring after SNOOZE_SECS ticks
        tick_at(7, 30, 0);
        pulse_user(1, 0);
        check("snz_ring",  32'(ringing), 0);
        check("snz_state", 32'(state),   2);
        pulse_user(1, 0);
        check("snz_again", 32'(state), 2);
        for (int i = 1; i <= SNOOZE_SECS; i++) begin
            tick_at(7, 31, i);
            check("snz_wait", 32'(ringing), (i < SNOOZE_SECS) ? 0 : 1);
        end
        check("rering_state", 32'(state), 1);
        pulse_user(1, 1);
        check("stop_wins", 32'(state), 0);

        // user snooze beats timeout on the final tick
        tick_at(7, 30, 0);
        for (int i = 1; i < RING_SECS; i++) tick_at(7, 30, i);
        snooze = 1;
        tick_at(7, 30, RING_SECS);
        snooze = 0;
        check("snz_beats_timeout", 32'(state), 2);
        pulse_user(0, 1);

        // alarm_on drop and setting both override ringing
        tick_at(7, 30, 0);
        alarm_on = 0;
        @(negedge clock);
        check("off_state", 32'(state),   0);
        check("off_ring",  32'(ringing), 0);
        alarm_on = 1;
        tick_at(7, 30, 0);
        setting = 1; sel_field = 0;
        pulse_step(1, 0);
        check("edit_state", 32'(state),     0);
        check("edit_min",   32'(alarm_min), 31);
        setting = 0;

        // asynchronous reset mid-snooze
        tick_at(7, 31, 0);
        pulse_user(1, 0);
        check("pre_reset_state", 32'(state), 2);
        #1 reset = 1'b1;
        #1;
        check("async_ring",  32'(ringing),    0);
        check("async_state", 32'(state),      0);
        check("async_hour",  32'(alarm_hour), 0);
        check("async_min",   32'(alarm_min),  0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Parametrised successor to the single-field alarm-hour setter: holds a settable alarm time (hour and minute), with up/down stepping and wrap-around in both directions.
- Compares the stored alarm against the running clock time and drives a ringing state machine with snooze and auto-timeout.
- Sits beside the time-keeping counters; consumes their current hour/min/sec and the 1 Hz enable pulse, and drives the buzzer/LED logic.

Parameters:
- W, 6, width of every time field.
- HOUR_MAX, 23, top value of the hour field; it wraps to 0.
- MIN_MAX, 59, top value of the minute field; it wraps to 0.
- RING_SECS, 60, seconds of ringing before auto-stop.
- SNOOZE_SECS, 300, seconds spent in snooze before ringing again.

Ports:
- clock  in  1  system clock; all flops are on the rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state.
- tick_sec  in  1  one-cycle pulse once per second.
- setting  in  1  alarm-setting mode.
- sel_field  in  1  field select: 0 = minute, 1 = hour.
- step_up  in  1  one-cycle pulse; increments the selected field.
- step_down  in  1  one-cycle pulse; decrements the selected field.
- alarm_on  in  1  arm enable.
- cur_hour  in  W  current clock hour.
- cur_min  in  W  current clock minute.
- cur_sec  in  W  current clock second.
- snooze  in  1  one-cycle pulse; snooze request.
- stop  in  1  one-cycle pulse; silence request.
- alarm_hour  out  W  stored alarm hour.
- alarm_min  out  W  stored alarm minute.
- ringing  out  1  registered; high while in state RING.
- state  out  2  FSM state code, for debug.

Behaviour:
- Reset:
  - alarm_hour = 0, alarm_min = 0.
  - State = IDLE, ringing = 0.
  - All internal counters = 0.
- Setting:
  - Acts only when setting = 1; step pulses are ignored when setting = 0.
  - step_up: field <= (field == MAX) ? 0 : field + 1.
  - step_down: field <= (field == 0) ? MAX : field - 1.
  - step_up and step_down in the same cycle: no change.
  - Hour and minute step independently; no carry between them.
  - The update takes effect on the next clock edge.
- FSM states: IDLE = 0, RING = 1, SNOOZE = 2. Code 3 is unreachable and recovers to IDLE.
- Global override: setting = 1 or alarm_on = 0 forces IDLE next cycle from any state.
  - All counters clear and ringing drops.
  - This has priority over every transition below.
- IDLE -> RING when all of the following hold in one cycle:
  - alarm_on = 1 and setting = 0;
  - tick_sec = 1;
  - cur_hour == alarm_hour, cur_min == alarm_min and cur_sec == 0.
  - The cur_sec == 0 condition makes the trigger fire once per matching minute.
  - ringing is high on the edge after the trigger cycle (1-cycle latency).
  - ring_cnt loads 0 on entry.
- RING:
  - Each tick_sec increments ring_cnt.
  - stop -> IDLE.
  - snooze -> SNOOZE, loading snz_cnt = 0.
  - stop and snooze together: stop wins.
  - tick_sec with ring_cnt == RING_SECS-1 -> IDLE (timeout).
  - A user pulse beats timeout in the same cycle.
- SNOOZE:
  - ringing = 0; each tick_sec increments snz_cnt.
  - stop -> IDLE.
  - tick_sec with snz_cnt == SNOOZE_SECS-1 -> RING, with ring_cnt = 0.
  - snooze pulses in SNOOZE are ignored; snoozing repeats without limit.
- Counter widths: $clog2(RING_SECS) and $clog2(SNOOZE_SECS), with a minimum of 1 bit.
- Reset asserted mid-ring or mid-snooze clears everything immediately (asynchronous).
- Editing the alarm while it rings forces IDLE through the setting override.

Decomposition:
- Shared package clock_pkg holds:
  - state encodings ST_IDLE, ST_RING, ST_SNOOZE;
  - default HOUR_MAX and MIN_MAX;
  - field-select constants SEL_MIN and SEL_HOUR.
- One natural sub-module, wrap_updown_cnt: parameters W and MAX; inputs inc, dec, en; asynchronous reset; wraps in both directions. Instantiated twice, for hour and minute.
- FSM and comparator stay in alarm_unit.

Test Plan:
- Reset, then setting = 1, sel_field = 1, 24 step_up pulses -> alarm_hour goes 1..23 then 0. One further step_down -> 23.
- sel_field = 0, step_up and step_down in the same cycle -> alarm_min unchanged. step_down from 0 -> 59.
- Alarm 07:30, alarm_on = 1, tick at cur = 07:30:00 -> ringing = 1 on the next edge. Tick at 07:30:01 with no match -> no re-trigger after stop.
- RING_SECS = 4: trigger, then 4 ticks with no input -> ringing falls after the 4th tick; state = IDLE.
- SNOOZE_SECS = 3: in RING, pulse snooze -> ringing = 0, state = 2. After 3 ticks -> ringing = 1 again. stop and snooze in the same cycle -> IDLE.
- During RING, drop alarm_on -> IDLE next cycle. Separately, assert reset mid-SNOOZE -> all outputs 0 with no clock edge needed.
